rx_fifo_rd_ctrl: RTL and testbench
==================================

# rx_fifo_rd_ctrl

Read-side controller for the PCS25G receive elastic FIFO. Holds the FIFO flushed until lanes are deskewed, pre-fills it to a start level, then streams 48-bit words (4 lanes x 12 bits) to the downstream datapath. It handles clock compensation by stalling when fill is low and recovers from overflow or starvation by flushing and re-syncing. Downstream data checkers use `out_sync` to excuse the discontinuity after every (re)start.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 words; `fifo_level` is DEPTH_LOG2+1 bits.
- START_LVL, 8: fill level required to start (FILL->RUN) or resume (STALL->RUN).
- LOW_LVL, 2: reads are made only while level > LOW_LVL. Legal range is 1 <= LOW_LVL < START_LVL.
- STALL_MAX, 255: maximum consecutive STALL cycles before a forced resync. Fits in 8 bits.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- lane_ok  in  1  lane deskew complete; level-sensitive.
- fifo_level  in  DEPTH_LOG2+1  current FIFO occupancy, valid in the same cycle.
- fifo_ovf  in  1  single-cycle pulse from the FIFO write side when a write was dropped.
- fifo_rd_data  in  48  FIFO read data, valid one cycle after `fifo_rd_en`.
- fifo_rd_en  out  1  FIFO pop, combinational.
- fifo_flush  out  1  FIFO clear, combinational from state.
- out_data  out  48  registered data word.
- out_valid  out  1  `out_data` is valid.
- out_sync  out  1  qualifies `out_valid`; first word after a (re)start.
- resync_cnt  out  8  saturating count of FLUSH entries caused by errors.
- state  out  3  encoding IDLE=0, FILL=1, RUN=2, STALL=3, FLUSH=4.

## Operation
- **IDLE**: `fifo_flush`=1. Go to FILL when `lane_ok`=1.
- **FILL**: no reads. Go to RUN when `fifo_level` >= START_LVL. Entering RUN from FILL sets `first_pend`.
- **RUN**: `fifo_rd_en` = (`fifo_level` > LOW_LVL). If `fifo_level` <= LOW_LVL, go to STALL; no read is made that cycle.
- **STALL**: no reads. The 8-bit stall counter increments each cycle.
  - Go to RUN when `fifo_level` >= START_LVL. The counter clears and `first_pend` is not set, because data continuity is preserved.
  - If the counter reaches STALL_MAX, go to FLUSH.
- **FLUSH**: `fifo_flush`=1 for exactly one cycle. `resync_cnt` increments (saturating at 255). Next state is FILL if `lane_ok`, else IDLE.
- In FILL, RUN or STALL, `fifo_ovf`=1 forces FLUSH next cycle, and `fifo_rd_en` is forced to 0 in that cycle.
- `lane_ok`=0 in any non-IDLE state forces IDLE next cycle with no `resync_cnt` increment. This has priority over `fifo_ovf`. `fifo_rd_en` is forced to 0 in that cycle.
- Sync tagging: a read issued while `first_pend`=1 carries sync through the pipeline; `first_pend` clears on that read.
- Pipeline:
  - Stage 1 registers rd_en/sync.
  - Stage 2 registers `fifo_rd_data` into `out_data`, with `out_valid` and `out_sync`.
- Whenever the state is IDLE or FLUSH, both stage valid bits clear, so in-flight words are discarded and never emitted.
- `out_data` holds its last value when `out_valid`=0.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, so `fifo_flush`=1.
  - `fifo_rd_en`=0.
  - `out_data`=0, `out_valid`=0, `out_sync`=0.
  - `resync_cnt`=0.
  - `first_pend`=0, stall counter=0.
- Latency: `fifo_rd_en` high in cycle N gives `out_valid` high in cycle N+2 carrying the word popped at N.
- In steady RUN with level > LOW_LVL, there is one read per cycle and `out_valid` is continuous.
- FILL->RUN: first `fifo_rd_en` is in the first RUN cycle, so the first `out_valid`+`out_sync` appears 2 cycles later.
- Reset mid-operation drops all state immediately; pipeline contents are lost.
- `fifo_level` == 2**DEPTH_LOG2 has no special handling; overflow is signalled only by `fifo_ovf`.

## Test plan
- Reset, `lane_ok`=0: `fifo_flush`=1, `fifo_rd_en`=0, `out_valid`=0, state=0. Raise `lane_ok`, hold level=7: state stays FILL with no reads. Level=8: RUN next cycle, and the first `out_valid` has `out_sync`=1 two cycles after the first read.
- Steady RUN with level 9 and `fifo_rd_data` = incrementing lane counters: `out_data` matches the popped words in order at 2-cycle latency. `out_sync`=1 on the first word only.
- Level drops to 2 in RUN: `fifo_rd_en`=0 that cycle, state=STALL. Level rises to 8: RUN resumes, `out_sync` stays 0, `resync_cnt` unchanged.
- Hold STALL with level 3 for 255 cycles: FLUSH, one-cycle `fifo_flush`, `resync_cnt`=1, then FILL.
- `fifo_ovf` pulse in RUN with 2 words in flight: those words are not emitted, FLUSH occurs, `resync_cnt` increments. After refill the first word has `out_sync`=1.
- `lane_ok` deasserted coincident with `fifo_ovf` in RUN: state goes to IDLE, `resync_cnt` unchanged, `fifo_flush` held at 1. Also check `resync_cnt` saturates at 255 after 300 forced overflows.

Source files
------------

// File: rtl/rx_fifo_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// rx_fifo_rd_ctrl_if
// Bundles the elastic-FIFO read port and the downstream word stream used by
// rx_fifo_rd_ctrl.
//   fifo_level   : FIFO occupancy, DEPTH_LOG2+1 bits
//   fifo_ovf     : one-cycle pulse when the write side dropped a word
//   fifo_rd_data : 48-bit read data, valid one cycle after fifo_rd_en
//   fifo_rd_en   : pop request (controller -> FIFO)
//   fifo_flush   : FIFO clear (controller -> FIFO)
//   out_data     : 48-bit word to the datapath (4 lanes x 12 bits)
//   out_valid    : out_data is valid
//   out_sync     : first word after a (re)start, qualifies out_valid
// Modport master is the controller side; slave is the FIFO/datapath side.
// ---------------------------------------------------------------------------
interface rx_fifo_rd_ctrl_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [DEPTH_LOG2:0] fifo_level;
    logic                fifo_ovf;
    logic [47:0]         fifo_rd_data;
    logic                fifo_rd_en;
    logic                fifo_flush;
    logic [47:0]         out_data;
    logic                out_valid;
    logic                out_sync;

    modport master (
        input  fifo_level, fifo_ovf, fifo_rd_data,
        output fifo_rd_en, fifo_flush, out_data, out_valid, out_sync
    );

    modport slave (
        output fifo_level, fifo_ovf, fifo_rd_data,
        input  fifo_rd_en, fifo_flush, out_data, out_valid, out_sync
    );
endinterface

// File: rtl/rx_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// rx_fifo_rd_ctrl
// Read-side controller for the PCS25G receive elastic FIFO. Keeps the FIFO
// flushed until lanes are deskewed, pre-fills it to START_LVL, then streams
// one 48-bit word per cycle. Stalls when fill is low (clock compensation) and
// flushes/re-syncs on overflow or on a stall that lasts too long.
// Ports:
//   clk        : sole clock
//   reset_n    : asynchronous active-low reset
//   lane_ok    : lane deskew complete (level)
//   bus        : FIFO read port + output word stream (master modport)
//   resync_cnt : saturating count of error-caused flushes
//   state      : current FSM state (IDLE=0 FILL=1 RUN=2 STALL=3 FLUSH=4)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | lanes not deskewed; FIFO held flushed
// FILL  | waiting for fifo_level >= START_LVL, no reads
// RUN   | one pop per cycle while fifo_level > LOW_LVL
// STALL | fill too low; wait for START_LVL, bounded by STALL_MAX cycles
// FLUSH | one-cycle FIFO clear after an error, then refill
// ---------------------------------------------------------------------------
module rx_fifo_rd_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int START_LVL  = 8,
    parameter int LOW_LVL    = 2,
    parameter int STALL_MAX  = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     lane_ok,
    rx_fifo_rd_ctrl_if.master        bus,
    output logic [7:0]               resync_cnt,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STALL = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    localparam logic [DEPTH_LOG2:0] START_L  = (DEPTH_LOG2 + 1)'(START_LVL);
    localparam logic [DEPTH_LOG2:0] LOW_L    = (DEPTH_LOG2 + 1)'(LOW_LVL);
    // Counter value seen during the STALL_MAX-th consecutive stall cycle.
    localparam logic [7:0]          STALL_TC = 8'(STALL_MAX - 1);

    state_t      state_q;
    logic [7:0]  stall_cnt;
    logic        first_pend;
    logic        s1_valid;
    logic        s1_sync;

    logic        active;
    logic        lane_drop;
    logic        ovf_err;
    logic        stall_tmo;
    logic        kill;
    logic        rd_en;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        active    = (state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_STALL);
        lane_drop = (state_q != ST_IDLE) && !lane_ok;
        ovf_err   = active && bus.fifo_ovf && !lane_drop;
        stall_tmo = (state_q == ST_STALL) && (stall_cnt == STALL_TC) &&
                    (bus.fifo_level < START_L);
        // kill is high whenever the current or the next state is IDLE/FLUSH,
        // so any word still in the pipeline is dropped instead of emitted.
        kill      = (state_q == ST_IDLE) || (state_q == ST_FLUSH) || !lane_ok ||
                    (active && bus.fifo_ovf) || stall_tmo;
        rd_en     = (state_q == ST_RUN) && lane_ok && !bus.fifo_ovf &&
                    (bus.fifo_level > LOW_L);
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.fifo_flush = (state_q == ST_IDLE) || (state_q == ST_FLUSH);
    assign state          = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            stall_cnt     <= '0;
            first_pend    <= 1'b0;
            resync_cnt    <= '0;
            s1_valid      <= 1'b0;
            s1_sync       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sync  <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            stall_cnt <= '0;

            if (lane_drop) begin
                state_q <= ST_IDLE;
            end else if (ovf_err) begin
                state_q    <= ST_FLUSH;
                resync_cnt <= sat_inc(resync_cnt);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (lane_ok) state_q <= ST_FILL;
                    end
                    ST_FILL: begin
                        if (bus.fifo_level >= START_L) begin
                            state_q    <= ST_RUN;
                            first_pend <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (bus.fifo_level <= LOW_L) state_q <= ST_STALL;
                    end
                    ST_STALL: begin
                        // Resume keeps data continuity, so no new sync tag.
                        if (bus.fifo_level >= START_L) begin
                            state_q <= ST_RUN;
                        end else if (stall_tmo) begin
                            state_q    <= ST_FLUSH;
                            resync_cnt <= sat_inc(resync_cnt);
                        end else begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end
                    ST_FLUSH: begin
                        state_q <= ST_FILL;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end

            if (rd_en) begin
                first_pend <= 1'b0;
            end else if ((state_q == ST_IDLE) || (state_q == ST_FLUSH)) begin
                first_pend <= 1'b0;
            end

            s1_valid      <= rd_en;
            s1_sync       <= rd_en && first_pend;
            bus.out_valid <= s1_valid && !kill;
            bus.out_sync  <= s1_valid && s1_sync && !kill;
            if (s1_valid && !kill) begin
                bus.out_data <= bus.fifo_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_rx_fifo_rd_ctrl.sv
module tb_rx_fifo_rd_ctrl;

    localparam int DL = 4;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_RUN   = 2;
    localparam int M_STALL = 3;
    localparam int M_FLUSH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lane_ok = 1'b0;
    logic [7:0] resync_cnt;
    logic [2:0] state;

    rx_fifo_rd_ctrl_if #(.DEPTH_LOG2(DL)) bus ();

    rx_fifo_rd_ctrl #(
        .DEPTH_LOG2(DL),
        .START_LVL (8),
        .LOW_LVL   (2),
        .STALL_MAX (255)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .lane_ok   (lane_ok),
        .bus       (bus),
        .resync_cnt(resync_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: spec-level state, a queue of popped words with the
    // cycle they are due at the output, and the last emitted word.
    typedef struct {
        int          emit;
        bit          sync;
        logic [47:0] data;
    } word_t;

    int          m_state;
    int          m_stall;
    int          m_resync;
    bit          m_first;
    word_t       m_pipe[$];
    logic [47:0] m_last;

    bit          v_lo;
    int          v_lvl;
    bit          v_ovf;
    bit          v_rd;

    logic [47:0] cur_data;
    logic [47:0] nxt_data;
    bit          rand_data = 1'b0;
    int          lane_cnt  = 0;

    typedef struct {
        bit lo;
        int lvl;
        bit ovf;
        int st;
        bit fl;
        bit rd;
        bit ov;
        bit sy;
        int rs;
    } vec_t;

    vec_t tbl[23];

    function automatic logic [47:0] gen_word();
        logic [63:0] r;
        int          k;
        if (rand_data) begin
            r = {$urandom, $urandom};
            return r[47:0];
        end
        k = lane_cnt * 4;
        lane_cnt++;
        return {12'(k + 3), 12'(k + 2), 12'(k + 1), 12'(k)};
    endfunction

    task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_stall  = 0;
        m_resync = 0;
        m_first  = 1'b0;
        m_pipe.delete();
        m_last   = '0;
    endtask

    // Drive one cycle's inputs (called just after a rising edge) and compare
    // all outputs against the model at the falling edge.
    task automatic apply(input bit lo, input int lvl, input bit ovf);
        word_t w;
        bit    exp_ov;
        bit    exp_sy;
        v_lo  = lo;
        v_lvl = lvl;
        v_ovf = ovf;
        lane_ok          = lo;
        bus.fifo_level   = (DL + 1)'(lvl);
        bus.fifo_ovf     = ovf;
        bus.fifo_rd_data = cur_data;

        if (m_state == M_IDLE || m_state == M_FLUSH) m_pipe.delete();
        exp_ov = 1'b0;
        exp_sy = 1'b0;
        if (m_pipe.size() > 0 && m_pipe[0].emit == cyc) begin
            w      = m_pipe.pop_front();
            exp_ov = 1'b1;
            exp_sy = w.sync;
            m_last = w.data;
        end
        v_rd = (m_state == M_RUN) && lo && !ovf && (lvl > 2);

        #4;
        chk("state",      48'(state),          48'(m_state));
        chk("fifo_flush", 48'(bus.fifo_flush), 48'(m_state == M_IDLE || m_state == M_FLUSH));
        chk("fifo_rd_en", 48'(bus.fifo_rd_en), 48'(v_rd));
        chk("out_valid",  48'(bus.out_valid),  48'(exp_ov));
        chk("out_sync",   48'(bus.out_sync),   48'(exp_sy));
        chk("out_data",   bus.out_data,        m_last);
        chk("resync_cnt", 48'(resync_cnt),     48'(m_resync));
    endtask

    task automatic step();
        word_t w;
        int    prev;
        prev = m_state;
        if (v_rd) begin
            w.emit = cyc + 2;
            w.sync = m_first;
            w.data = nxt_data;
            m_pipe.push_back(w);
            m_first = 1'b0;
        end
        if (m_state != M_IDLE && !v_lo) begin
            m_state = M_IDLE;
        end else if (v_ovf && (m_state == M_FILL || m_state == M_RUN || m_state == M_STALL)) begin
            m_state = M_FLUSH;
            if (m_resync < 255) m_resync++;
        end else begin
            case (m_state)
                M_IDLE:  if (v_lo) m_state = M_FILL;
                M_FILL:  if (v_lvl >= 8) begin m_state = M_RUN; m_first = 1'b1; end
                M_RUN:   if (v_lvl <= 2) m_state = M_STALL;
                M_STALL: begin
                    if (v_lvl >= 8) m_state = M_RUN;
                    else if (m_stall + 1 == 255) begin
                        m_state = M_FLUSH;
                        if (m_resync < 255) m_resync++;
                    end
                end
                default: m_state = M_FILL;
            endcase
        end
        m_stall = (prev == M_STALL && m_state == M_STALL) ? m_stall + 1 : 0;

        @(posedge clk);
        #1;
        cyc++;
        cur_data = nxt_data;
        nxt_data = gen_word();
    endtask

    task automatic cycle(input bit lo, input int lvl, input bit ovf);
        apply(lo, lvl, ovf);
        step();
    endtask

    // Assert reset mid-cycle, check values while it is held, release it
    // one cycle later well away from the clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_state",      48'(state),          48'(0));
        chk("rst_fifo_flush", 48'(bus.fifo_flush), 48'(1));
        chk("rst_fifo_rd_en", 48'(bus.fifo_rd_en), 48'(0));
        chk("rst_out_valid",  48'(bus.out_valid),  48'(0));
        chk("rst_out_sync",   48'(bus.out_sync),   48'(0));
        chk("rst_out_data",   bus.out_data,        48'(0));
        chk("rst_resync_cnt", 48'(resync_cnt),     48'(0));
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc++;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 7, 0,  1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 7, 0,  1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 8, 0,  1, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 9, 0,  2, 0, 1, 0, 0, 0};
        tbl[6]  = '{1, 9, 0,  2, 0, 1, 0, 0, 0};
        tbl[7]  = '{1, 9, 0,  2, 0, 1, 1, 1, 0};
        tbl[8]  = '{1, 9, 0,  2, 0, 1, 1, 0, 0};
        tbl[9]  = '{1, 2, 0,  2, 0, 0, 1, 0, 0};
        tbl[10] = '{1, 3, 0,  3, 0, 0, 1, 0, 0};
        tbl[11] = '{1, 8, 0,  3, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 9, 0,  2, 0, 1, 0, 0, 0};
        tbl[13] = '{1, 9, 0,  2, 0, 1, 0, 0, 0};
        tbl[14] = '{1, 9, 0,  2, 0, 1, 1, 0, 0};
        tbl[15] = '{1, 9, 1,  2, 0, 0, 1, 0, 0};
        tbl[16] = '{1, 9, 0,  4, 1, 0, 0, 0, 1};
        tbl[17] = '{1, 9, 0,  1, 0, 0, 0, 0, 1};
        tbl[18] = '{1, 9, 0,  2, 0, 1, 0, 0, 1};
        tbl[19] = '{1, 9, 0,  2, 0, 1, 0, 0, 1};
        tbl[20] = '{1, 9, 0,  2, 0, 1, 1, 1, 1};
        tbl[21] = '{0, 9, 1,  2, 0, 0, 1, 0, 1};
        tbl[22] = '{0, 9, 0,  0, 1, 0, 0, 0, 1};

        bus.fifo_level   = '0;
        bus.fifo_ovf     = 1'b0;
        bus.fifo_rd_data = '0;
        model_reset();
        cur_data = gen_word();
        nxt_data = gen_word();

        @(posedge clk);
        #1;
        do_reset();

        // Directed vectors: start-up, steady run, stall/resume, overflow
        // flush with words in flight, lane loss coincident with overflow.
        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].lo, tbl[i].lvl, tbl[i].ovf);
            chk("tbl_state",  48'(state),          48'(tbl[i].st));
            chk("tbl_flush",  48'(bus.fifo_flush), 48'(tbl[i].fl));
            chk("tbl_rd_en",  48'(bus.fifo_rd_en), 48'(tbl[i].rd));
            chk("tbl_valid",  48'(bus.out_valid),  48'(tbl[i].ov));
            chk("tbl_sync",   48'(bus.out_sync),   48'(tbl[i].sy));
            chk("tbl_resync", 48'(resync_cnt),     48'(tbl[i].rs));
            step();
        end

        // Stall timeout: 255 consecutive STALL cycles, then one FLUSH cycle.
        cycle(1, 0, 0);
        cycle(1, 8, 0);
        cycle(1, 2, 0);
        for (int i = 0; i < 255; i++) begin
            apply(1, 3, 0);
            if (i == 254) chk("stall_last", 48'(state), 48'(3));
            step();
        end
        apply(1, 3, 0);
        chk("tmo_flush_state", 48'(state),          48'(4));
        chk("tmo_flush",       48'(bus.fifo_flush), 48'(1));
        chk("tmo_resync",      48'(resync_cnt),     48'(2));
        step();
        apply(1, 3, 0);
        chk("tmo_refill_state", 48'(state),          48'(1));
        chk("tmo_refill_flush", 48'(bus.fifo_flush), 48'(0));
        step();

        // Saturation: 300 forced overflows from FILL.
        for (int i = 0; i < 300; i++) begin
            cycle(1, 3, 1);
            cycle(1, 3, 0);
        end
        apply(1, 3, 0);
        chk("resync_sat", 48'(resync_cnt), 48'(255));
        step();

        // Randomised traffic against the model, with one mid-run reset.
        rand_data = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                do_reset();
            end
            cycle(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 16)),
                  ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
